// File: rtl/mxint8_block_assembler_if.sv
// -----------------------------------------------------------------------------
// mxint8_block_assembler_if
// Purpose : bundles the serial element stream, the parallel block output and
//           the block status signals of the MXINT8 block assembler.
// Signals :
//   in_valid_i / in_ready_o   element handshake (source -> assembler)
//   in_elem_i                 MXINT8 element
//   in_scale_i                shared E8M0 scale, taken with element 0 only
//   out_elements_o            assembled block, element i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   out_scale_o               latched block scale
//   out_valid_o / out_ready_i block handshake (assembler -> negate stage)
//   data_ready_o              one-cycle pulse on the first cycle of out_valid_o
//   block_count_o             blocks consumed since reset (wrapping)
//   sat_flag_o                present only with MXINT8_SAT_NEG_EN defined
// Modports: slave  = the assembler itself
//           master = the surrounding source / sink
// -----------------------------------------------------------------------------
interface mxint8_block_assembler_if #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
);
    logic                             in_valid_i;
    logic                             in_ready_o;
    logic [ELEM_WIDTH-1:0]            in_elem_i;
    logic [SCALE_WIDTH-1:0]           in_scale_i;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0] out_elements_o;
    logic [SCALE_WIDTH-1:0]           out_scale_o;
    logic                             out_valid_o;
    logic                             out_ready_i;
    logic                             data_ready_o;
    logic [CNT_WIDTH-1:0]             block_count_o;
`ifdef MXINT8_SAT_NEG_EN
    logic                             sat_flag_o;
`endif

    modport slave (
        input  in_valid_i,
        input  in_elem_i,
        input  in_scale_i,
        input  out_ready_i,
        output in_ready_o,
        output out_elements_o,
        output out_scale_o,
        output out_valid_o,
        output data_ready_o,
        output block_count_o
`ifdef MXINT8_SAT_NEG_EN
        , output sat_flag_o
`endif
    );

    modport master (
        output in_valid_i,
        output in_elem_i,
        output in_scale_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_elements_o,
        input  out_scale_o,
        input  out_valid_o,
        input  data_ready_o,
        input  block_count_o
`ifdef MXINT8_SAT_NEG_EN
        , input sat_flag_o
`endif
    );
endinterface

// File: rtl/mxint8_block_assembler.sv
// -----------------------------------------------------------------------------
// mxint8_block_assembler
// Purpose : collects BLOCK_SIZE serial MXINT8 elements plus one shared scale
//           into a parallel block for the negate stage. The block is held
//           stable (out_valid_o high) until out_ready_i, and data_ready_o
//           pulses on the first cycle the block is presented.
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mxint8_block_assembler_if.slave (see interface header)
// Option  : MXINT8_SAT_NEG_EN -- clamp the most negative element code to the
//           next code up (0x80 -> 0x81 for 8 bits) so the downstream negation
//           is exactly representable, and drive bus.sat_flag_o.
// -----------------------------------------------------------------------------
module mxint8_block_assembler #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mxint8_block_assembler_if.slave   bus
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [ELEM_WIDTH-1:0] MOST_NEG = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [IDX_W-1:0]       wr_idx_reg;
    logic [IDX_W-1:0]       wr_idx_next;
    logic                   first_reg;
    logic [SCALE_WIDTH-1:0] scale_reg;
    logic [CNT_WIDTH-1:0]   count_reg;

    logic                   accept;
    logic                   accept_last;
    logic                   consume;
    logic [ELEM_WIDTH-1:0]  elem_store;

    // The handshakes are qualified by state, so an element offered during
    // FULL (even in the consume cycle) is never taken.
    assign accept      = bus.in_valid_i && (state_reg == FILL);
    assign accept_last = accept && (wr_idx_reg == LAST_IDX);
    assign consume     = bus.out_ready_i && (state_reg == FULL);

`ifdef MXINT8_SAT_NEG_EN
    logic clamp;
    logic sat_flag_reg;

    assign clamp      = (bus.in_elem_i == MOST_NEG);
    assign elem_store = clamp ? (MOST_NEG | ELEM_WIDTH'(1)) : bus.in_elem_i;

    // Accumulates over the block being filled; cleared when the block is
    // handed off so the next block starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_reg <= 1'b0;
        end else if (consume) begin
            sat_flag_reg <= 1'b0;
        end else if (accept && clamp) begin
            sat_flag_reg <= 1'b1;
        end
    end

    assign bus.sat_flag_o = sat_flag_reg;
`else
    assign elem_store = bus.in_elem_i;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (accept_last) state_next = FULL;
            FULL:    if (consume)     state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // first_reg is only ever set on the edge that enters FULL, so gating it
    // with FULL yields exactly one pulse per block.
    always_comb begin
        bus.in_ready_o   = (state_reg == FILL);
        bus.out_valid_o  = (state_reg == FULL);
        bus.data_ready_o = (state_reg == FULL) && first_reg;
    end

    // ---------------- datapath ----------------
    always_comb begin
        wr_idx_next = wr_idx_reg;
        if (accept_last) begin
            wr_idx_next = '0;
        end else if (accept) begin
            wr_idx_next = wr_idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_reg <= '0;
            first_reg  <= 1'b0;
            scale_reg  <= '0;
            count_reg  <= '0;
        end else begin
            wr_idx_reg <= wr_idx_next;
            first_reg  <= accept_last;
            if (accept && (wr_idx_reg == '0)) begin
                scale_reg <= bus.in_scale_i;
            end
            // Natural binary wrap from all-ones back to zero.
            if (consume) begin
                count_reg <= count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // One register per slot; a slot changes only when it is the write target,
    // so the whole block is frozen while in FULL.
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_slot
        logic [ELEM_WIDTH-1:0] slot_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (accept && (wr_idx_reg == IDX_W'(gi))) begin
                slot_reg <= elem_store;
            end
        end

        assign bus.out_elements_o[gi*ELEM_WIDTH +: ELEM_WIDTH] = slot_reg;
    end

    assign bus.out_scale_o   = scale_reg;
    assign bus.block_count_o = count_reg;

endmodule

// File: tb/tb_mxint8_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_mxint8_block_assembler
// Drives randomized element streams into the assembler and checks the
// presented blocks against a reference model built from plain arrays:
// the expected block is simply the sequence of elements handed over, with
// the most-negative-code clamp applied when MXINT8_SAT_NEG_EN is defined.
// -----------------------------------------------------------------------------
module tb_mxint8_block_assembler;
    localparam int BS = 32;
    localparam int EW = 8;
    localparam int SW = 8;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mxint8_block_assembler_if #(
        .BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW), .CNT_WIDTH(CW)
    ) bus ();

    mxint8_block_assembler #(
        .BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [EW-1:0] exp_elem [BS];
    logic [SW-1:0] exp_scale;
    logic [CW-1:0] exp_count;
    bit            exp_sat;

    // Storage rule: with saturation enabled the value -2.0 is not allowed
    // and becomes the smallest representable value above it.
    function automatic logic [EW-1:0] stored(input logic [EW-1:0] e);
`ifdef MXINT8_SAT_NEG_EN
        if (e == {1'b1, {(EW-1){1'b0}}}) return {1'b1, {(EW-2){1'b0}}, 1'b1};
`endif
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Streams n elements (mode 0: ramp, 1: random, 2: random with slot 3 =
    // most negative code), optionally with random idle gaps. Every cycle
    // before an accept the assembler must still be in its fill phase.
    task automatic drive_block(input int mode, input int n, input int gap_max);
        logic [EW-1:0] e;
        logic [SW-1:0] s;
        int k;
        k = 0;
        exp_sat = 0;
        while (k < n) begin
            vectors++;
            if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL fill_phase elem=%0d: in_ready=%b out_valid=%b data_ready=%b, required 1 0 0",
                         k, bus.in_ready_o, bus.out_valid_o, bus.data_ready_o);
            end
            if (gap_max > 0 && $urandom_range(0, gap_max) != 0) begin
                bus.in_valid_i = 1'b0;
                bus.in_elem_i  = EW'($urandom);
                bus.in_scale_i = SW'($urandom);
            end else begin
                case (mode)
                    0: begin
                        e = EW'(k);
                        s = (k == 0) ? 8'h7F : 8'h05;
                    end
                    1: begin
                        e = EW'($urandom);
                        s = SW'($urandom);
                    end
                    default: begin
                        e = EW'($urandom);
                        if (e == 8'h80) e = 8'h7F;
                        if (k == 3) e = 8'h80;
                        s = SW'($urandom);
                    end
                endcase
                bus.in_valid_i = 1'b1;
                bus.in_elem_i  = e;
                bus.in_scale_i = s;
                exp_elem[k] = stored(e);
                if (k == 0) exp_scale = s;
                if (stored(e) != e) exp_sat = 1;
                k++;
            end
            tick;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready_o); end
        vectors++;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid_o); end
        vectors++;
        if (bus.data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b, required 0", bus.data_ready_o); end
        vectors++;
        if (bus.block_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d, required 0", bus.block_count_o); end
        vectors++;
        if (bus.out_scale_o !== '0 || bus.out_elements_o !== '0) begin
            errors++;
            $display("FAIL reset_store: scale=%h elements=%h, required all zero", bus.out_scale_o, bus.out_elements_o);
        end
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        drive_block(0, BS, 0);
        vectors++;
        if ({bus.out_valid_o, bus.data_ready_o, bus.in_ready_o} !== 3'b110) begin
            errors++;
            $display("FAIL basic_present: out_valid/data_ready/in_ready=%b, required 110",
                     {bus.out_valid_o, bus.data_ready_o, bus.in_ready_o});
        end
        vectors++;
        if (bus.out_scale_o !== 8'h7F) begin errors++; $display("FAIL basic_scale: got %h, required 7f", bus.out_scale_o); end
        for (int i = 0; i < BS; i++) begin
            vectors++;
            if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                errors++;
                $display("FAIL basic_slot[%0d]: got %h, required %h", i, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
            end
        end
`ifdef MXINT8_SAT_NEG_EN
        vectors++;
        if (bus.sat_flag_o !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b, required 0", bus.sat_flag_o); end
`endif
        tick;
        vectors++;
        if (bus.data_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse_width: data_ready=%b out_valid=%b, required 0 1", bus.data_ready_o, bus.out_valid_o);
        end
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== exp_count || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_consume: count=%0d out_valid=%b in_ready=%b, required %0d 0 1",
                     bus.block_count_o, bus.out_valid_o, bus.in_ready_o, exp_count);
        end
        $display("block consumed (ramp), count=%0d", bus.block_count_o);
    endtask

    task automatic test_hold_and_collide;
        int pulses;
        pulses = 0;
        drive_block(1, BS, 0);
        for (int c = 0; c < 10; c++) begin
            if (bus.data_ready_o === 1'b1) pulses++;
            vectors++;
            if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_state cyc=%0d: in_ready=%b out_valid=%b, required 0 1", c, bus.in_ready_o, bus.out_valid_o);
            end
            vectors++;
            if (bus.out_scale_o !== exp_scale) begin
                errors++;
                $display("FAIL hold_scale cyc=%0d: got %h, required %h", c, bus.out_scale_o, exp_scale);
            end
            for (int i = 0; i < BS; i++) begin
                if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                    errors++;
                    $display("FAIL hold_slot[%0d] cyc=%0d: got %h, required %h", i, c, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
                end
            end
            vectors++;
            bus.in_valid_i = 1'b1;
            bus.in_elem_i  = EW'($urandom);
            bus.in_scale_i = SW'($urandom);
            tick;
        end
        vectors++;
        if (pulses != 1) begin errors++; $display("FAIL hold_pulse_count: got %0d, required 1", pulses); end
        // Consume while an element is offered: it must be dropped.
        bus.in_valid_i  = 1'b1;
        bus.in_elem_i   = 8'hAA;
        bus.in_scale_i  = 8'h33;
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== exp_count) begin
            errors++;
            $display("FAIL collide_count: got %0d, required %0d", bus.block_count_o, exp_count);
        end
        $display("block consumed (held), count=%0d", bus.block_count_o);
        // Back-to-back: the next block starts on the very next cycle.
        drive_block(1, BS, 0);
        vectors++;
        if (bus.out_valid_o !== 1'b1 || bus.data_ready_o !== 1'b1 || bus.out_scale_o !== exp_scale) begin
            errors++;
            $display("FAIL b2b_present: out_valid=%b data_ready=%b scale=%h, required 1 1 %h",
                     bus.out_valid_o, bus.data_ready_o, bus.out_scale_o, exp_scale);
        end
        for (int i = 0; i < BS; i++) begin
            vectors++;
            if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                errors++;
                $display("FAIL b2b_slot[%0d]: got %h, required %h", i, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
            end
        end
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== exp_count) begin
            errors++;
            $display("FAIL b2b_count: got %0d, required %0d", bus.block_count_o, exp_count);
        end
        $display("block consumed (back-to-back), count=%0d", bus.block_count_o);
    endtask

    task automatic test_gaps;
        drive_block(1, BS, 3);
        vectors++;
        if (bus.out_valid_o !== 1'b1 || bus.data_ready_o !== 1'b1 || bus.out_scale_o !== exp_scale) begin
            errors++;
            $display("FAIL gaps_present: out_valid=%b data_ready=%b scale=%h, required 1 1 %h",
                     bus.out_valid_o, bus.data_ready_o, bus.out_scale_o, exp_scale);
        end
        for (int i = 0; i < BS; i++) begin
            vectors++;
            if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                errors++;
                $display("FAIL gaps_slot[%0d]: got %h, required %h", i, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
            end
        end
`ifdef MXINT8_SAT_NEG_EN
        vectors++;
        if (bus.sat_flag_o !== exp_sat) begin errors++; $display("FAIL gaps_sat: got %b, required %b", bus.sat_flag_o, exp_sat); end
`endif
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== exp_count) begin
            errors++;
            $display("FAIL gaps_count: got %0d, required %0d", bus.block_count_o, exp_count);
        end
        $display("block consumed (gapped), count=%0d", bus.block_count_o);
    endtask

    task automatic test_reset_mid;
        drive_block(1, 17, 1);
        rst_n = 1'b0;
        #2;
        vectors++;
        if (bus.block_count_o !== '0 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: count=%0d in_ready=%b out_valid=%b, required 0 1 0",
                     bus.block_count_o, bus.in_ready_o, bus.out_valid_o);
        end
        tick;
        vectors++;
        if (bus.out_elements_o !== '0 || bus.out_scale_o !== '0 || bus.data_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_store: elements=%h scale=%h data_ready=%b, required zeros",
                     bus.out_elements_o, bus.out_scale_o, bus.data_ready_o);
        end
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        drive_block(1, BS, 0);
        vectors++;
        if (bus.out_valid_o !== 1'b1 || bus.data_ready_o !== 1'b1 || bus.out_scale_o !== exp_scale) begin
            errors++;
            $display("FAIL midreset_present: out_valid=%b data_ready=%b scale=%h, required 1 1 %h",
                     bus.out_valid_o, bus.data_ready_o, bus.out_scale_o, exp_scale);
        end
        for (int i = 0; i < BS; i++) begin
            vectors++;
            if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                errors++;
                $display("FAIL midreset_slot[%0d]: got %h, required %h", i, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
            end
        end
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== 16'd1) begin
            errors++;
            $display("FAIL midreset_count: got %0d, required 1", bus.block_count_o);
        end
        $display("block consumed (after reset), count=%0d", bus.block_count_o);
    endtask

    task automatic test_sat;
        logic [EW-1:0] want3;
`ifdef MXINT8_SAT_NEG_EN
        want3 = 8'h81;
`else
        want3 = 8'h80;
`endif
        drive_block(2, BS, 0);
        vectors++;
        if (bus.out_elements_o[3*EW +: EW] !== want3) begin
            errors++;
            $display("FAIL sat_slot3: got %h, required %h", bus.out_elements_o[3*EW +: EW], want3);
        end
        for (int i = 0; i < BS; i++) begin
            vectors++;
            if (bus.out_elements_o[i*EW +: EW] !== exp_elem[i]) begin
                errors++;
                $display("FAIL sat_slot[%0d]: got %h, required %h", i, bus.out_elements_o[i*EW +: EW], exp_elem[i]);
            end
        end
`ifdef MXINT8_SAT_NEG_EN
        vectors++;
        if (bus.sat_flag_o !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b, required 1", bus.sat_flag_o); end
`endif
        bus.out_ready_i = 1'b1;
        tick;
        bus.out_ready_i = 1'b0;
        exp_count++;
        vectors++;
        if (bus.block_count_o !== exp_count) begin
            errors++;
            $display("FAIL sat_count: got %0d, required %0d", bus.block_count_o, exp_count);
        end
`ifdef MXINT8_SAT_NEG_EN
        vectors++;
        if (bus.sat_flag_o !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b, required 0", bus.sat_flag_o); end
`endif
        $display("block consumed (saturation), count=%0d", bus.block_count_o);
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_elem_i   = '0;
        bus.in_scale_i  = '0;
        bus.out_ready_i = 1'b0;
        exp_scale       = '0;
        exp_count       = '0;
        exp_sat         = 0;
        for (int i = 0; i < BS; i++) exp_elem[i] = '0;

        test_reset;
        test_basic;
        test_hold_and_collide;
        test_gaps;
        test_reset_mid;
        test_sat;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
